// File: rtl/debug_slave_sysclk_bridge.sv
`default_nettype none
// ============================================================================
// Module   : debug_slave_sysclk_bridge
// Brief    : System-clock side of a virtual-JTAG debug slave. Oversamples the
//            scan strobes, runs a capture/shift/update register and issues
//            each update as a valid/ready command with a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module debug_slave_sysclk_bridge #(
    parameter int SR_W        = 38,
    parameter int NUM_CH      = 4,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vs_tck,
    input  logic                     vs_tdi,
    input  logic                     vs_cdr,
    input  logic                     vs_sdr,
    input  logic                     vs_udr,
    input  logic                     vs_uir,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [NUM_CH*SR_W-1:0]   cap_data,
    output logic                     tdo,
    output logic [IR_W-1:0]          ir_out,
    output logic [SR_W-1:0]          jdo,
    output logic                     act_valid,
    input  logic                     act_ready,
    output logic [IR_W-1:0]          act_ch,
    output logic                     act_take,
    output logic                     ir_update,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int NB = IR_W + 6;

    logic [SYNC_STAGES-1:0][NB-1:0] r_sync;
    logic [NB-1:0]                  w_async;
    logic [NB-1:0]                  w_s;

    logic                           r_tck_d;
    logic                           r_udr_d;
    logic                           r_uir_d;

    logic [SR_W-1:0]                r_sr;
    logic [IR_W-1:0]                r_latch_ir;
    logic [SR_W-1:0]                r_jdo;
    logic                           r_act_valid;
    logic [IR_W-1:0]                r_act_ch;
    logic                           r_act_take;
    logic                           r_ir_update;
    logic                           r_overrun;

    logic                           w_s_tck;
    logic                           w_s_tdi;
    logic                           w_s_cdr;
    logic                           w_s_sdr;
    logic                           w_s_udr;
    logic                           w_s_uir;
    logic [IR_W-1:0]                w_s_ir;
    logic                           w_tck_rise;
    logic                           w_udr_rise;
    logic                           w_uir_rise;
    logic                           w_ch_ok;
    logic                           w_slot_free;
    logic [SR_W-1:0]                w_cap;

    assign w_async = {vs_tck, vs_tdi, vs_cdr, vs_sdr, vs_udr, vs_uir, ir_in};
    assign w_s     = r_sync[SYNC_STAGES-1];

    assign w_s_tck = w_s[IR_W+5];
    assign w_s_tdi = w_s[IR_W+4];
    assign w_s_cdr = w_s[IR_W+3];
    assign w_s_sdr = w_s[IR_W+2];
    assign w_s_udr = w_s[IR_W+1];
    assign w_s_uir = w_s[IR_W];
    assign w_s_ir  = w_s[IR_W-1:0];

    assign w_tck_rise = w_s_tck & ~r_tck_d;
    assign w_udr_rise = w_s_udr & ~r_udr_d;
    assign w_uir_rise = w_s_uir & ~r_uir_d;

    // One extra bit keeps the compare correct when NUM_CH == 2**IR_W.
    assign w_ch_ok     = ({1'b0, r_latch_ir} < (IR_W+1)'(NUM_CH));
    assign w_slot_free = ~r_act_valid | act_ready;

    // Unmatched (invalid) channel numbers fall through to an all-zero capture.
    always_comb begin
        w_cap = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_latch_ir == IR_W'(k)) begin
                w_cap = cap_data[k*SR_W +: SR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_tck_d <= 1'b0;
            r_udr_d <= 1'b0;
            r_uir_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], w_async};
            r_tck_d <= w_s_tck;
            r_udr_d <= w_s_udr;
            r_uir_d <= w_s_uir;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr        <= '0;
            r_latch_ir  <= '0;
            r_jdo       <= '0;
            r_act_valid <= 1'b0;
            r_act_ch    <= '0;
            r_act_take  <= 1'b0;
            r_ir_update <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_ir_update <= w_uir_rise;
            if (w_uir_rise) begin
                r_latch_ir <= w_s_ir;
            end

            if (w_tck_rise) begin
                if (w_s_cdr) begin
                    r_sr <= w_cap;
                end else if (w_s_sdr) begin
                    r_sr <= {w_s_tdi, r_sr[SR_W-1:1]};
                end
            end

            if (r_act_valid && act_ready) begin
                r_act_valid <= 1'b0;
            end
            if (overrun_clr) begin
                r_overrun <= 1'b0;
            end

            // A load in the accept cycle overrides the clear of act_valid above.
            if (w_udr_rise && w_ch_ok) begin
                if (w_slot_free) begin
                    r_jdo       <= r_sr;
                    r_act_ch    <= r_latch_ir;
                    r_act_take  <= r_sr[SR_W-1];
                    r_act_valid <= 1'b1;
                end else begin
                    r_overrun   <= 1'b1;
                end
            end
        end
    end

    assign tdo       = r_sr[0];
    assign ir_out    = r_latch_ir;
    assign jdo       = r_jdo;
    assign act_valid = r_act_valid;
    assign act_ch    = r_act_ch;
    assign act_take  = r_act_take;
    assign ir_update = r_ir_update;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
